logo_scroll_ctrl: RTL and testbench

//   Generates the horizontal offset 'delt' consumed by the logo letter painters (11-bit, added to x origin).

---
 rtl/logo_scroll_if.sv | 17 +
 rtl/logo_scroll_ctrl.sv | 101 ++++++++++
 tb/tb_logo_scroll_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/logo_scroll_if.sv
// logo_scroll_if: control/scan inputs and offset outputs of the logo scroller.
//   enable, restart : animation control from the system
//   x, y            : scan column/row from the VGA timing block
//   delt            : logo horizontal offset to the letter painters
//   dir_left        : 1 while heading (or paused heading) left
//   frame_tick      : one-cycle pulse per frame
interface logo_scroll_if;
    logic        enable;
    logic        restart;
    logic [10:0] x;
    logic [10:0] y;
    logic [10:0] delt;
    logic        dir_left;
    logic        frame_tick;
    modport master (output enable, restart, x, y, input delt, dir_left, frame_tick);
    modport slave  (input enable, restart, x, y, output delt, dir_left, frame_tick);
endinterface

// File: rtl/logo_scroll_ctrl.sv
// logo_scroll_ctrl: animates the logo offset back and forth, one update per frame.
//   clk_i  : system clock (may run faster than the pixel clock)
//   rst_ni : asynchronous reset, active low
//   bus    : slave side of logo_scroll_if (enable, restart, x, y in; delt, dir_left, frame_tick out)
module logo_scroll_ctrl #(
    parameter int unsigned V_VISIBLE       = 600,
    parameter int unsigned STEP            = 2,
    parameter int unsigned FRAMES_PER_STEP = 1,
    parameter int unsigned DELT_MAX        = 200,
    parameter int unsigned PAUSE_FRAMES    = 60
) (
    input logic         clk_i,
    input logic         rst_ni,
    logo_scroll_if.slave bus
);
    localparam logic [10:0] V11    = 11'(V_VISIBLE);
    localparam logic [10:0] DMAX   = 11'(DELT_MAX);
    localparam logic [11:0] STEP12 = 12'(STEP);
    localparam logic [15:0] FLAST  = 16'(FRAMES_PER_STEP - 1);
    localparam logic [15:0] PLAST  = 16'(PAUSE_FRAMES - 1);

    typedef enum logic [2:0] {IDLE, RIGHT, PAUSE_R, LEFT, PAUSE_L} state_t;

    state_t      state_q, state_d;
    logic [10:0] delt_q, delt_d;
    logic        dir_q, dir_d;
    logic [15:0] fcnt_q, fcnt_d;
    logic [15:0] pcnt_q, pcnt_d;
    logic        match, match_q, tick_q;
    logic [11:0] sum, dif;
    logic [10:0] up, dn;

    assign match = (bus.x == 11'd0) && (bus.y == V11);
    // 12-bit arithmetic so neither direction can wrap before clamping
    assign sum   = {1'b0, delt_q} + STEP12;
    assign dif   = {1'b0, delt_q} - STEP12;
    assign up    = (sum > {1'b0, DMAX}) ? DMAX : sum[10:0];
    assign dn    = dif[11] ? 11'd0 : dif[10:0];

    always_comb begin
        state_d = state_q;
        delt_d  = delt_q;
        dir_d   = dir_q;
        fcnt_d  = fcnt_q;
        pcnt_d  = pcnt_q;
        if (bus.restart) begin
            state_d = bus.enable ? RIGHT : IDLE;
            delt_d  = '0;
            dir_d   = 1'b0;
            fcnt_d  = '0;
            pcnt_d  = '0;
        end else if (state_q == IDLE) begin
            state_d = bus.enable ? (dir_q ? LEFT : RIGHT) : IDLE;
        end else if (!bus.enable) begin
            state_d = IDLE;
        end else if (tick_q) begin
            if (state_q == RIGHT || state_q == LEFT) begin
                if (fcnt_q == FLAST) begin
                    fcnt_d = '0;
                    delt_d = (state_q == LEFT) ? dn : up;
                    if ((state_q == RIGHT && up == DMAX) || (state_q == LEFT && dn == 11'd0)) begin
                        state_d = (state_q == RIGHT) ? PAUSE_R : PAUSE_L;
                        pcnt_d  = '0;
                    end
                end else begin
                    fcnt_d = fcnt_q + 16'd1;
                end
            end else if (pcnt_q == PLAST) begin
                state_d = (state_q == PAUSE_R) ? LEFT : RIGHT;
                dir_d   = (state_q == PAUSE_R);
            end else begin
                pcnt_d = pcnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            delt_q  <= '0;
            dir_q   <= 1'b0;
            fcnt_q  <= '0;
            pcnt_q  <= '0;
            match_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            delt_q  <= delt_d;
            dir_q   <= dir_d;
            fcnt_q  <= fcnt_d;
            pcnt_q  <= pcnt_d;
            match_q <= match;
            // rising edge of the match gives one tick per frame however long x,y dwell
            tick_q  <= match & ~match_q;
        end
    end

    assign bus.delt       = delt_q;
    assign bus.dir_left   = dir_q;
    assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_logo_scroll_ctrl.sv
// tb_logo_scroll_ctrl: three scroller configurations driven in lockstep and checked
// against a frame-level reference model, a vector table and directed corner cases.
module tb_logo_scroll_ctrl;
    localparam int ST[3] = '{2, 3, 2};
    localparam int FP[3] = '{1, 1, 3};
    localparam int PF[3] = '{60, 5, 4};
    localparam int DM = 200;

    logic        clk = 1'b0, rst_n = 1'b1, en = 1'b0, rs = 1'b0;
    logic [10:0] x = 11'd5, y = 11'd0;
    logic [10:0] d_o[3];
    logic        dl_o[3], ft_o[3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logo_scroll_if b();
        assign b.enable  = en;
        assign b.restart = rs;
        assign b.x       = x;
        assign b.y       = y;
        logo_scroll_ctrl #(.V_VISIBLE(600), .STEP(ST[g]), .FRAMES_PER_STEP(FP[g]),
                           .DELT_MAX(DM), .PAUSE_FRAMES(PF[g])) u (
            .clk_i(clk), .rst_ni(rst_n), .bus(b));
        assign d_o[g]  = b.delt;
        assign dl_o[g] = b.dir_left;
        assign ft_o[g] = b.frame_tick;
    end

    int m_d[3], m_f[3], m_p[3];
    bit m_dir[3], m_act[3], m_pz[3];
    bit m_tick, m_mprev;
    int total = 0, bad = 0, ticks = 0;

    typedef struct {bit en; int n; int d0; bit dr0; int d1; int d2;} vec_t;
    vec_t tbl[9];

    task automatic chk(string nm, int a, int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, a, e);
        end
    endtask

    task automatic mreset();
        for (int i = 0; i < 3; i++) begin
            m_d[i] = 0; m_f[i] = 0; m_p[i] = 0; m_dir[i] = 0; m_act[i] = 0; m_pz[i] = 0;
        end
        m_tick = 0;
        m_mprev = 0;
    endtask

    // a frame tick while running either burns a pause frame or advances toward a step
    task automatic mtick(int i);
        if (m_pz[i]) begin
            if (m_p[i] == PF[i] - 1) begin
                m_pz[i] = 0;
                m_dir[i] = !m_dir[i];
            end else m_p[i]++;
        end else if (m_f[i] == FP[i] - 1) begin
            m_f[i] = 0;
            m_d[i] = m_dir[i] ? ((m_d[i] - ST[i] < 0) ? 0 : m_d[i] - ST[i])
                              : ((m_d[i] + ST[i] > DM) ? DM : m_d[i] + ST[i]);
            if (m_d[i] == (m_dir[i] ? 0 : DM)) begin
                m_pz[i] = 1;
                m_p[i] = 0;
            end
        end else m_f[i]++;
    endtask

    task automatic mstep();
        bit mt;
        mt = (x == 11'd0 && y == 11'd600);
        if (!rst_n) begin
            mreset();
            return;
        end
        for (int i = 0; i < 3; i++) begin
            if (rs) begin
                m_d[i] = 0; m_dir[i] = 0; m_f[i] = 0; m_p[i] = 0; m_pz[i] = 0; m_act[i] = en;
            end else if (!en) begin
                m_act[i] = 0;
                m_pz[i] = 0;
            end else if (!m_act[i]) m_act[i] = 1;
            else if (m_tick) mtick(i);
        end
        m_tick = mt && !m_mprev;
        m_mprev = mt;
    endtask

    task automatic cyc();
        @(posedge clk);
        mstep();
        @(negedge clk);
        if (ft_o[0]) ticks++;
        for (int i = 0; i < 3; i++)
            chk($sformatf("cyc_u%0d", i), int'(d_o[i]) * 4 + int'(dl_o[i]) * 2 + int'(ft_o[i]),
                m_d[i] * 4 + int'(m_dir[i]) * 2 + int'(m_tick));
    endtask

    task automatic frame(int h = 4, int g = 2);
        x = 11'd0;
        y = 11'd600;
        repeat (h) cyc();
        x = 11'd5;
        repeat (g) cyc();
    endtask

    task automatic chk0(string nm, int d, bit dr);
        chk({nm, "_delt"}, int'(d_o[0]), d);
        chk({nm, "_dir"}, int'(dl_o[0]), int'(dr));
    endtask

    initial begin
        tbl[0] = '{1, 1, 2, 0, 3, 0};
        tbl[1] = '{1, 49, 100, 0, 150, 32};
        tbl[2] = '{1, 50, 200, 0, 116, 66};
        tbl[3] = '{0, 10, 200, 0, 116, 66};
        tbl[4] = '{1, 1, 200, 0, 113, 66};
        tbl[5] = '{1, 1, 200, 0, 110, 68};
        tbl[6] = '{1, 59, 200, 1, -1, -1};
        tbl[7] = '{1, 1, 198, 1, -1, -1};
        tbl[8] = '{1, 39, 120, 1, -1, -1};
        mreset();
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++)
            chk($sformatf("reset_u%0d", i), int'(d_o[i]) * 4 + int'(dl_o[i]) * 2 + int'(ft_o[i]), 0);
        repeat (2) cyc();
        rst_n = 1'b1;
        ticks = 0;
        repeat (5) frame();
        chk("idle_ticks", ticks, 5);
        chk0("idle", 0, 0);
        for (int k = 0; k < 9; k++) begin
            en = tbl[k].en;
            repeat (tbl[k].n) frame();
            chk0($sformatf("vec%0d", k), tbl[k].d0, tbl[k].dr0);
            if (tbl[k].d1 >= 0) begin
                chk($sformatf("vec%0d_u1", k), int'(d_o[1]), tbl[k].d1);
                chk($sformatf("vec%0d_u2", k), int'(d_o[2]), tbl[k].d2);
            end
        end
        // restart landing on the same cycle as a frame tick
        x = 11'd0;
        y = 11'd600;
        cyc();
        rs = 1'b1;
        cyc();
        rs = 1'b0;
        chk0("restart", 0, 0);
        repeat (2) cyc();
        x = 11'd5;
        repeat (2) cyc();
        frame();
        chk0("restart_run", 2, 0);
        chk("restart_u1", int'(d_o[1]), 3);
        chk("restart_u2", int'(d_o[2]), 0);
        repeat (99) frame();
        chk0("rt_top", 200, 0);
        repeat (60) frame();
        chk0("rt_turn", 200, 1);
        repeat (5) frame();
        chk0("rt_left", 190, 1);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++)
            chk($sformatf("arst_u%0d", i), int'(d_o[i]) * 4 + int'(dl_o[i]) * 2 + int'(ft_o[i]), 0);
        mreset();
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (100) frame();
        chk0("r2_top", 200, 0);
        repeat (60) frame();
        chk0("r2_turn", 200, 1);
        repeat (100) frame();
        chk0("r2_bottom", 0, 1);
        repeat (59) frame();
        chk0("r2_pause_l", 0, 1);
        frame();
        chk0("r2_turn_r", 0, 0);
        frame();
        chk0("r2_first_r", 2, 0);
        for (int n = 0; n < 300; n++) begin
            en = ($urandom_range(0, 9) != 0);
            rs = ($urandom_range(0, 24) == 0);
            x = ($urandom_range(0, 7) == 0) ? 11'($urandom_range(1, 2)) : 11'd0;
            y = ($urandom_range(0, 7) == 0) ? 11'(599 + 2 * $urandom_range(0, 1)) : 11'd600;
            repeat ($urandom_range(1, 5)) begin
                cyc();
                rs = 1'b0;
            end
            if ($urandom_range(0, 9) == 0) en = ~en;
            x = 11'($urandom_range(0, 3));
            y = 11'($urandom_range(0, 1023));
            repeat ($urandom_range(1, 3)) cyc();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
